// File: rtl/stream_window_aligner_pkg.sv
// Shared constants and the aligner state type for the activation read path.
package NVP_v1_constants;

  localparam int NUMBER_OF_READ_STREAMS       = 3;
  localparam int ACTIVATION_BANK_BIT_WIDTH    = 8;
  localparam int ACTIVATION_BUFFER_BANK_COUNT = 4;
  localparam int STREAM_ALIGNER_FIFO_DEPTH    = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } stream_aligner_state_t;

endpackage

// File: rtl/stream_window_aligner_if.sv
// Handshake bundle between the read streams, the aligner and the PE front-end.
// The aligner uses the slave view; whatever feeds streams and takes windows uses master.
interface stream_window_aligner_if
  import NVP_v1_constants::*;
#(
  parameter int NUMBER_OF_READ_STREAMS = NVP_v1_constants::NUMBER_OF_READ_STREAMS,
  parameter int STREAM_DATA_WIDTH      = NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH *
                                         NVP_v1_constants::ACTIVATION_BUFFER_BANK_COUNT
);

  logic [NUMBER_OF_READ_STREAMS-1:0][STREAM_DATA_WIDTH-1:0] i_stream_data;
  logic [NUMBER_OF_READ_STREAMS-1:0]                        i_stream_valid;
  logic [NUMBER_OF_READ_STREAMS-1:0]                        o_stream_ready;
  logic [NUMBER_OF_READ_STREAMS-1:0][STREAM_DATA_WIDTH-1:0] o_window_data;
  logic                                                     o_window_valid;
  logic                                                     i_window_ready;
  logic                                                     o_window_last;

  modport slave (
    input  i_stream_data, i_stream_valid, i_window_ready,
    output o_stream_ready, o_window_data, o_window_valid, o_window_last
  );

  modport master (
    output i_stream_data, i_stream_valid, i_window_ready,
    input  o_stream_ready, o_window_data, o_window_valid, o_window_last
  );

endinterface

// File: rtl/stream_window_aligner_sync_fifo.sv
// Small synchronous FIFO holding one read stream's words until every
// enabled row has a word for the same column. Depth must be a power of two
// so the pointers wrap for free.
module stream_sync_fifo
  import NVP_v1_constants::*;
#(
  parameter int DATA_WIDTH = ACTIVATION_BANK_BIT_WIDTH * ACTIVATION_BUFFER_BANK_COUNT,
  parameter int DEPTH      = STREAM_ALIGNER_FIFO_DEPTH
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    push,
  input  logic [DATA_WIDTH-1:0]   push_data,
  input  logic                    pop,
  output logic [DATA_WIDTH-1:0]   head,
  output logic [$clog2(DEPTH):0]  count
);

  localparam int PTR_WIDTH   = $clog2(DEPTH);
  localparam int COUNT_WIDTH = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0]  mem [DEPTH];
  logic [PTR_WIDTH-1:0]   wr_ptr;
  logic [PTR_WIDTH-1:0]   rd_ptr;
  logic [COUNT_WIDTH-1:0] count_q;
  logic                   do_push;
  logic                   do_pop;

  assign do_push = push & (count_q < COUNT_WIDTH'(DEPTH));
  assign do_pop  = pop & (count_q != '0);
  assign head    = mem[rd_ptr];
  assign count   = count_q;

  // Storage array; contents need no reset because the count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers and occupancy; a flush empties the FIFO just like reset.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_WIDTH'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_WIDTH'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + COUNT_WIDTH'(1);
        2'b01:   count_q <= count_q - COUNT_WIDTH'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/stream_window_aligner.sv
// Buffers each enabled read stream and releases one column-aligned,
// multi-row activation window per handshake, flagging the last column.
module stream_window_aligner
  import NVP_v1_constants::*;
#(
  parameter int NUMBER_OF_READ_STREAMS = NVP_v1_constants::NUMBER_OF_READ_STREAMS,
  parameter int STREAM_DATA_WIDTH      = NVP_v1_constants::ACTIVATION_BANK_BIT_WIDTH *
                                         NVP_v1_constants::ACTIVATION_BUFFER_BANK_COUNT,
  parameter int FIFO_DEPTH             = NVP_v1_constants::STREAM_ALIGNER_FIFO_DEPTH,
  parameter int LINE_LENGTH_WIDTH      = 16
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [NUMBER_OF_READ_STREAMS-1:0] i_stream_mask,
  input  logic [LINE_LENGTH_WIDTH-1:0]      i_line_length,
  stream_window_aligner_if.slave            bus,
  output logic                              o_line_done,
  output logic                              o_busy
);

  localparam int COUNT_WIDTH = $clog2(FIFO_DEPTH) + 1;

  stream_aligner_state_t state_q, state_d;

  logic [NUMBER_OF_READ_STREAMS-1:0]                        mask_q;
  logic [LINE_LENGTH_WIDTH-1:0]                             length_q;
  logic [LINE_LENGTH_WIDTH-1:0]                             column_q;
  logic                                                     noop_done_q;
  logic [NUMBER_OF_READ_STREAMS-1:0]                        stream_ready;
  logic [NUMBER_OF_READ_STREAMS-1:0]                        push;
  logic [NUMBER_OF_READ_STREAMS-1:0]                        pop;
  logic [NUMBER_OF_READ_STREAMS-1:0][STREAM_DATA_WIDTH-1:0] fifo_head;
  logic [NUMBER_OF_READ_STREAMS-1:0][COUNT_WIDTH-1:0]       fifo_count;
  logic                                                     fifo_flush;
  logic                                                     window_valid;
  logic                                                     window_last;
  logic                                                     window_fire;
  logic                                                     start_line;
  logic                                                     start_noop;

  assign push = stream_ready & bus.i_stream_valid;
  assign pop  = {NUMBER_OF_READ_STREAMS{window_fire}} & mask_q;

  for (genvar g = 0; g < NUMBER_OF_READ_STREAMS; g++) begin : g_stream
    stream_sync_fifo #(
      .DATA_WIDTH (STREAM_DATA_WIDTH),
      .DEPTH      (FIFO_DEPTH)
    ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .flush     (fifo_flush),
      .push      (push[g]),
      .push_data (bus.i_stream_data[g]),
      .pop       (pop[g]),
      .head      (fifo_head[g]),
      .count     (fifo_count[g])
    );
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state plus handshake decode; abort wins over a same-cycle fire,
  // and outside RUN the FIFOs are held empty so leftovers never leak.
  always_comb begin
    state_d      = state_q;
    stream_ready = '0;
    window_valid = 1'b0;
    window_last  = 1'b0;
    window_fire  = 1'b0;
    fifo_flush   = 1'b0;
    start_line   = 1'b0;
    start_noop   = 1'b0;
    case (state_q)
      IDLE: begin
        fifo_flush = 1'b1;
        if (i_start) begin
          if ((i_stream_mask != '0) && (i_line_length != '0)) begin
            start_line = 1'b1;
            state_d    = RUN;
          end else begin
            start_noop = 1'b1;
          end
        end
      end
      RUN: begin
        window_valid = 1'b1;
        for (int i = 0; i < NUMBER_OF_READ_STREAMS; i++) begin
          stream_ready[i] = mask_q[i] & (fifo_count[i] < COUNT_WIDTH'(FIFO_DEPTH));
          if (mask_q[i] && (fifo_count[i] == '0)) window_valid = 1'b0;
        end
        window_last = window_valid & (column_q == length_q - LINE_LENGTH_WIDTH'(1));
        if (i_abort) begin
          state_d = FLUSH;
        end else begin
          window_fire = window_valid & bus.i_window_ready;
          if (window_fire && window_last) state_d = IDLE;
        end
      end
      FLUSH: begin
        fifo_flush = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Line parameters, column counter and the deferred no-op completion pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask_q      <= '0;
      length_q    <= '0;
      column_q    <= '0;
      noop_done_q <= 1'b0;
    end else begin
      noop_done_q <= start_noop;
      if (start_line) begin
        mask_q   <= i_stream_mask;
        length_q <= i_line_length;
        column_q <= '0;
      end else if (window_fire) begin
        column_q <= column_q + LINE_LENGTH_WIDTH'(1);
      end
    end
  end

  // Window rows come straight from the FIFO heads; masked rows and idle cycles read zero.
  always_comb begin
    bus.o_window_data = '0;
    for (int i = 0; i < NUMBER_OF_READ_STREAMS; i++) begin
      if (window_valid && mask_q[i]) bus.o_window_data[i] = fifo_head[i];
    end
  end

  assign bus.o_stream_ready = stream_ready;
  assign bus.o_window_valid = window_valid;
  assign bus.o_window_last  = window_last;
  assign o_line_done        = noop_done_q | (window_fire & window_last);
  assign o_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_stream_window_aligner.sv
// Randomized scoreboard bench for stream_window_aligner: each line's expected
// windows are built from the words handed to each stream, and a monitor
// compares every accepted window against them in order.
module tb_stream_window_aligner;

  localparam int NS           = 3;
  localparam int W            = 32;
  localparam int LLW          = 16;
  localparam int DEPTH        = 4;
  localparam int MAX_WORDS    = 32;
  localparam int LINE_TIMEOUT = 500;

  typedef struct {
    logic [NS-1:0][W-1:0] data;
    logic                 last;
  } window_t;

  logic           clk = 1'b0;
  logic           reset;
  logic           i_start;
  logic           i_abort;
  logic [NS-1:0]  i_stream_mask;
  logic [LLW-1:0] i_line_length;
  logic           o_line_done;
  logic           o_busy;

  stream_window_aligner_if #(.NUMBER_OF_READ_STREAMS(NS), .STREAM_DATA_WIDTH(W)) bus ();

  stream_window_aligner #(
    .NUMBER_OF_READ_STREAMS (NS),
    .STREAM_DATA_WIDTH      (W),
    .FIFO_DEPTH             (DEPTH),
    .LINE_LENGTH_WIDTH      (LLW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_stream_mask (i_stream_mask),
    .i_line_length (i_line_length),
    .bus           (bus),
    .o_line_done   (o_line_done),
    .o_busy        (o_busy)
  );

  always #5 clk = ~clk;

  int            checks = 0;
  int            failures = 0;
  int            cycle_cnt = 0;
  bit            monitor_en = 1'b0;
  logic [NS-1:0] cur_mask = '0;
  int            done_expected = 0;
  int            done_seen = 0;
  int            first_push [NS];
  int            acc_count [NS];
  int            first_valid;
  int            first_fire;
  int            last_fire;
  bit            line_finished;
  window_t       exp_q [$];
  logic [W-1:0]  words [NS][MAX_WORDS];

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic check_val(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Monitor side of the scoreboard: every accepted window pops one expectation.
  task automatic check_output();
    window_t e;
    check_val("ready_disabled_stream", bus.o_stream_ready & ~cur_mask, '0);
    if (o_line_done) done_seen++;
    if (!bus.o_window_valid) begin
      check_val("idle_window_data_zero", bus.o_window_data, '0);
    end else if (first_valid < 0) begin
      first_valid = cycle_cnt;
    end
    if (bus.o_window_valid && bus.i_window_ready) begin
      if (first_fire < 0) first_fire = cycle_cnt;
      last_fire = cycle_cnt;
      if (exp_q.size() == 0) begin
        check_val("unexpected_window", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check_val("window_data", bus.o_window_data, e.data);
        check_val("window_last", bus.o_window_last, e.last);
        check_val("line_done_on_fire", o_line_done, e.last);
      end
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (monitor_en) check_output();
  end

  // Upstream driver: holds each word valid until accepted, optional gaps, stream 2 may start late.
  task automatic drive_streams(input int avail, input int delay2, input bit gaps);
    int            idx [NS];
    int            cyc;
    logic [NS-1:0] acc;
    for (int s = 0; s < NS; s++) idx[s] = 0;
    cyc = 0;
    while (!line_finished) begin
      @(negedge clk);
      acc = bus.i_stream_valid & bus.o_stream_ready;
      for (int s = 0; s < NS; s++)
        if (acc[s] && first_push[s] < 0) first_push[s] = cycle_cnt + 1;
      @(posedge clk);
      #1;
      cyc++;
      for (int s = 0; s < NS; s++) begin
        if (acc[s]) begin
          idx[s]++;
          acc_count[s]++;
          bus.i_stream_valid[s] = 1'b0;
        end
        if (!bus.i_stream_valid[s] && idx[s] < avail && cyc > ((s == 2) ? delay2 : 0) &&
            (!gaps || $urandom_range(0, 3) != 0))
          bus.i_stream_valid[s] = 1'b1;
        bus.i_stream_data[s] = (idx[s] < avail) ? words[s][idx[s]] : '0;
      end
    end
  endtask

  // Downstream ready: 0 always, 1 random, 2 held low for hold cycles, 3 only while windows are owed.
  task automatic drive_window_ready(input int mode, input int hold, input logic [NS-1:0] mask);
    int cyc;
    cyc = 0;
    while (!line_finished) begin
      case (mode)
        0:       bus.i_window_ready = 1'b1;
        1:       bus.i_window_ready = 1'($urandom_range(0, 1));
        2:       bus.i_window_ready = (cyc >= hold);
        default: bus.i_window_ready = (exp_q.size() > 0);
      endcase
      if (mode == 2 && cyc == hold - 1) begin
        @(negedge clk);
        for (int s = 0; s < NS; s++)
          if (mask[s]) check_val("pushes_before_stall", acc_count[s], DEPTH);
        check_val("ready_low_when_full", bus.o_stream_ready, '0);
      end
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  // Runs one line: builds the expected windows, starts the line, drives both sides.
  task automatic apply_stimulus(input logic [NS-1:0] mask, input int len, input int delay2,
                                input int ready_mode, input int hold, input int extra,
                                input bit gaps, input bit do_abort);
    window_t e;
    int      n_win;
    int      to;
    int      exp_first;
    n_win = do_abort ? 2 : len;
    for (int s = 0; s < NS; s++)
      for (int c = 0; c < len + extra; c++) words[s][c] = $urandom();
    for (int c = 0; c < n_win; c++) begin
      for (int s = 0; s < NS; s++) e.data[s] = mask[s] ? words[s][c] : '0;
      e.last = (c == len - 1);
      exp_q.push_back(e);
    end
    if (!do_abort) done_expected++;
    for (int s = 0; s < NS; s++) begin
      first_push[s] = -1;
      acc_count[s]  = 0;
    end
    first_valid   = -1;
    first_fire    = -1;
    last_fire     = -1;
    line_finished = 1'b0;

    @(posedge clk);
    #1;
    i_start       = 1'b1;
    i_stream_mask = mask;
    i_line_length = LLW'(len);
    @(posedge clk);
    #1;
    i_start  = 1'b0;
    cur_mask = mask;

    fork
      begin
        to = 0;
        while (exp_q.size() != 0 && to < LINE_TIMEOUT) begin
          @(posedge clk);
          to++;
        end
        check_val("line_timeout_windows_left", exp_q.size(), 0);
        exp_q.delete();
        line_finished = 1'b1;
      end
      drive_streams(len + extra, delay2, gaps);
      drive_window_ready(ready_mode, hold, mask);
    join
    bus.i_stream_valid = '0;
    bus.i_window_ready = 1'b0;

    exp_first = -1;
    for (int s = 0; s < NS; s++)
      if (mask[s] && first_push[s] > exp_first) exp_first = first_push[s];
    check_val("first_window_latency", first_valid, exp_first);
    if (ready_mode == 0 && !gaps && delay2 == 0)
      check_val("one_window_per_cycle", last_fire - first_fire, len - 1);

    if (do_abort) begin
      @(posedge clk);
      #1;
      i_abort = 1'b1;
      @(posedge clk);
      #1;
      i_abort  = 1'b0;
      cur_mask = '0;
      @(negedge clk);
      check_val("busy_in_flush", o_busy, 1);
      @(posedge clk);
      #1;
      @(negedge clk);
      check_val("idle_after_flush", o_busy, 0);
    end else begin
      @(negedge clk);
      check_val("idle_after_line", o_busy, 0);
      cur_mask = '0;
    end
    check_val("line_done_count", done_seen, done_expected);
  endtask

  // A start with zero mask or zero length only produces a delayed done pulse.
  task automatic apply_noop(input logic [NS-1:0] mask, input int len);
    done_expected++;
    cur_mask = '0;
    @(posedge clk);
    #1;
    i_start       = 1'b1;
    i_stream_mask = mask;
    i_line_length = LLW'(len);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    check_val("noop_done_pulse", o_line_done, 1);
    check_val("noop_not_busy", o_busy, 0);
    @(posedge clk);
    #1;
    @(negedge clk);
    check_val("noop_done_single_cycle", o_line_done, 0);
    check_val("noop_done_count", done_seen, done_expected);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset              = 1'b1;
    i_start            = 1'b0;
    i_abort            = 1'b0;
    i_stream_mask      = '0;
    i_line_length      = '0;
    bus.i_stream_valid = '0;
    bus.i_stream_data  = '0;
    bus.i_window_ready = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("reset_stream_ready", bus.o_stream_ready, '0);
    check_val("reset_window_valid", bus.o_window_valid, 0);
    check_val("reset_window_data", bus.o_window_data, '0);
    check_val("reset_window_last", bus.o_window_last, 0);
    check_val("reset_line_done", o_line_done, 0);
    check_val("reset_busy", o_busy, 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    monitor_en = 1'b1;

    $display("[TB] full mask, length 4, back-to-back");
    apply_stimulus(3'b111, 4, 0, 0, 0, 0, 1'b0, 1'b0);
    $display("[TB] mask 101, stream 1 driven but disabled");
    apply_stimulus(3'b101, 2, 0, 0, 0, 0, 1'b0, 1'b0);
    $display("[TB] stream 2 delayed by 3 cycles");
    apply_stimulus(3'b111, 6, 3, 0, 0, 0, 1'b0, 1'b0);
    $display("[TB] downstream stalled, FIFOs fill");
    apply_stimulus(3'b111, 6, 0, 2, 10, 0, 1'b0, 1'b0);
    $display("[TB] abort after 2 of 8 columns");
    apply_stimulus(3'b111, 8, 0, 3, 0, 0, 1'b0, 1'b1);
    $display("[TB] length 1 after abort, extra words past line end");
    apply_stimulus(3'b111, 1, 0, 0, 0, 2, 1'b0, 1'b0);
    $display("[TB] no-op starts");
    apply_noop(3'b111, 0);
    apply_noop(3'b000, 5);

    $display("[TB] randomized lines");
    for (int n = 0; n < 8; n++)
      apply_stimulus(NS'($urandom_range(1, 7)), $urandom_range(1, 10), $urandom_range(0, 4),
                     $urandom_range(0, 1), 0, $urandom_range(0, 3),
                     1'($urandom_range(0, 1)), 1'b0);

    $display("[TB] reset in the middle of a line");
    monitor_en = 1'b0;
    @(posedge clk);
    #1;
    i_start       = 1'b1;
    i_stream_mask = 3'b111;
    i_line_length = LLW'(5);
    @(posedge clk);
    #1;
    i_start            = 1'b0;
    bus.i_stream_valid = 3'b111;
    bus.i_stream_data  = {32'hAAAA_0003, 32'hAAAA_0002, 32'hAAAA_0001};
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    check_val("busy_before_reset", o_busy, 1);
    check_val("window_valid_before_reset", bus.o_window_valid, 1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check_val("midreset_stream_ready", bus.o_stream_ready, '0);
    check_val("midreset_window_valid", bus.o_window_valid, 0);
    check_val("midreset_window_data", bus.o_window_data, '0);
    check_val("midreset_busy", o_busy, 0);
    bus.i_stream_valid = '0;
    monitor_en         = 1'b1;
    apply_stimulus(3'b011, 3, 0, 0, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
